// File: rtl/multi_mode_buffer_feeder.sv
// Edge feeder for one side of the roundabout systolic array: buffers whole edge
// vectors in a small FIFO and replays them with a per-lane diagonal skew.
module multi_mode_buffer_feeder #(
    parameter int DATA_WIDTH  = 8,
    parameter int PE_PER_SIDE = 6,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH*PE_PER_SIDE-1:0] in_data,
    input  logic                              in_last,
    input  logic                              reverse_skew,
    output logic [DATA_WIDTH*PE_PER_SIDE-1:0] edge_out,
    output logic [PE_PER_SIDE-1:0]            edge_valid,
    output logic                              busy,
    output logic                              done
);
    localparam int VEC_W = DATA_WIDTH * PE_PER_SIDE;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int DC_W  = (PE_PER_SIDE > 1) ? $clog2(PE_PER_SIDE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } state_t;

    logic [VEC_W-1:0] r_mem_data [FIFO_DEPTH];
    logic             r_mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    state_t           r_state;
    state_t           w_state_next;
    logic [DC_W-1:0]  r_drain_cnt;
    logic [DC_W-1:0]  w_drain_cnt_next;
    logic             r_skew_mode;
    logic             w_skew_mode_next;
    logic             r_done;
    logic             w_done_next;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [VEC_W-1:0] w_head_data;
    logic             w_head_last;

    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_push      = in_valid && !w_full;
    assign w_head_data = r_mem_data[r_rd_ptr];
    assign w_head_last = r_mem_last[r_rd_ptr];

    assign in_ready = !w_full;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;

    // FIFO storage carries no reset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= in_data;
            r_mem_last[r_wr_ptr] <= in_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= PTR_W'(r_wr_ptr + 1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= PTR_W'(r_rd_ptr + 1'b1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= CNT_W'(r_count + 1'b1);
                2'b01:   r_count <= CNT_W'(r_count - 1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= '0;
            r_skew_mode <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= w_drain_cnt_next;
            r_skew_mode <= w_skew_mode_next;
            r_done      <= w_done_next;
        end
    end

    // A popped last vector always enters DRAIN, even when it is the first pop from IDLE.
    always_comb begin
        w_state_next     = r_state;
        w_drain_cnt_next = r_drain_cnt;
        w_skew_mode_next = r_skew_mode;
        w_done_next      = 1'b0;
        w_pop            = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop            = 1'b1;
                    w_skew_mode_next = reverse_skew;
                    w_state_next     = S_STREAM;
                    if (w_head_last) begin
                        w_state_next     = S_DRAIN;
                        w_drain_cnt_next = DC_W'(PE_PER_SIDE - 1);
                    end
                end
            end
            S_STREAM: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head_last) begin
                        w_state_next     = S_DRAIN;
                        w_drain_cnt_next = DC_W'(PE_PER_SIDE - 1);
                    end
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_drain_cnt_next = DC_W'(r_drain_cnt - 1'b1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Each lane keeps only as many stages as its longer delay needs in either mode.
    genvar gi;
    generate
        for (gi = 0; gi < PE_PER_SIDE; gi++) begin : g_lane
            localparam int D_FWD = gi;
            localparam int D_REV = PE_PER_SIDE - 1 - gi;
            localparam int DEPTH = ((D_FWD > D_REV) ? D_FWD : D_REV) + 1;

            logic [DATA_WIDTH-1:0] r_data [DEPTH];
            logic [DEPTH-1:0]      r_vld;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        r_data[j] <= '0;
                    end
                    r_vld <= '0;
                end else begin
                    r_data[0] <= w_pop ? w_head_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
                    r_vld[0]  <= w_pop;
                    for (int j = 1; j < DEPTH; j++) begin
                        r_data[j] <= r_data[j-1];
                        r_vld[j]  <= r_vld[j-1];
                    end
                end
            end

            assign edge_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_skew_mode ? r_data[D_REV] : r_data[D_FWD];
            assign edge_valid[gi] = r_skew_mode ? r_vld[D_REV] : r_vld[D_FWD];
        end
    endgenerate
endmodule

// File: tb/tb_multi_mode_buffer_feeder.sv
// Bench for multi_mode_buffer_feeder with 4 lanes of 8 bits and a 4-deep FIFO;
// a per-lane scoreboard checks every valid lane value in order.
module tb_multi_mode_buffer_feeder;
    localparam int DW = 8;
    localparam int PE = 4;
    localparam int FD = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          in_last;
    logic          reverse_skew;
    logic [31:0]   edge_out;
    logic [3:0]    edge_valid;
    logic          busy;
    logic          done;

    multi_mode_buffer_feeder #(
        .DATA_WIDTH  (DW),
        .PE_PER_SIDE (PE),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .reverse_skew (reverse_skew),
        .edge_out     (edge_out),
        .edge_valid   (edge_valid),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ecnt;
    logic [7:0] exp_q [4][$];
    logic [7:0] mon_ev;
    logic [3:0] hist_v [16];
    logic       hist_d [16];

    typedef struct {
        logic        rev;
        int          e;
        logic [3:0]  valid;
        logic [31:0] out;
        logic        busy;
        logic        done;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_vec(input logic [31:0] d, input logic last, output int acc_cyc);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        acc_cyc  = -1;
        for (int w = 0; w < 20; w++) begin
            if (in_ready) begin
                for (int k = 0; k < 4; k++) exp_q[k].push_back(d[k*8 +: 8]);
                tick();
                acc_cyc = cyc;
                $display("push cyc=%0d data=%08h last=%0d", cyc, d, last);
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        if (acc_cyc < 0) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got no accept, required accept within 20 cycles");
        end
    endtask

    task automatic rec();
        ecnt++;
        hist_v[ecnt] = edge_valid;
        hist_d[ecnt] = done;
    endtask

    // Lane k must be valid at edge e exactly when a pop happened at edge e-k.
    task automatic check_hist(input string tag, input logic [15:0] pop_mask, input int done_e);
        logic [3:0] ev;
        for (int e = 1; e <= 10; e++) begin
            for (int k = 0; k < 4; k++) ev[k] = (e - k >= 0) ? pop_mask[e-k] : 1'b0;
            chk($sformatf("%s_valid_e%0d", tag, e), {28'd0, hist_v[e]}, {28'd0, ev});
            chk($sformatf("%s_done_e%0d", tag, e), {31'd0, hist_d[e]}, {31'd0, (e == done_e)});
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (edge_valid[k]) begin
                    if (exp_q[k].size() == 0) begin
                        bad++;
                        $display("FAIL lane%0d_extra: got %02h, required no output", k, edge_out[k*8 +: 8]);
                    end else begin
                        mon_ev = exp_q[k].pop_front();
                        if (edge_out[k*8 +: 8] !== mon_ev) begin
                            bad++;
                            $display("FAIL lane%0d_data: got %02h expected %02h", k, edge_out[k*8 +: 8], mon_ev);
                        end
                    end
                end else if (edge_out[k*8 +: 8] !== 8'h00) begin
                    bad++;
                    $display("FAIL lane%0d_idle_zero: got %02h expected 00", k, edge_out[k*8 +: 8]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc0;
        int accs [5];
        int waited;

        tbl[0]  = '{1'b0, 1, 4'b0001, 32'h00000001, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 2, 4'b0010, 32'h00000200, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 3, 4'b0100, 32'h00030000, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 4, 4'b1000, 32'h04000000, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 5, 4'b0000, 32'h00000000, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 6, 4'b0000, 32'h00000000, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1, 4'b1000, 32'h04000000, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 2, 4'b0100, 32'h00030000, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 3, 4'b0010, 32'h00000200, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 4, 4'b0001, 32'h00000001, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 5, 4'b0000, 32'h00000000, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 6, 4'b0000, 32'h00000000, 1'b0, 1'b0};

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_last      = 1'b0;
        reverse_skew = 1'b0;
        tick();
        tick();
        chk("rst_edge_out", edge_out, 32'h0);
        chk("rst_edge_valid", {28'd0, edge_valid}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_done", {31'd0, done}, 32'h0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'h1);
        rst_n = 1'b1;
        tick();

        // Single vector, forward then reverse; the skew select flips after the latch edge.
        for (int r = 0; r < 2; r++) begin
            int e;
            reverse_skew = r[0];
            push_vec(32'h04030201, 1'b1, acc);
            e = 0;
            for (int i = 0; i < 12; i++) begin
                if (tbl[i].rev == r[0]) begin
                    while (e < tbl[i].e) begin
                        tick();
                        e++;
                        if (e == 1) reverse_skew = ~reverse_skew;
                    end
                    chk($sformatf("t%0d_valid_e%0d", r, e), {28'd0, edge_valid}, {28'd0, tbl[i].valid});
                    chk($sformatf("t%0d_out_e%0d", r, e), edge_out, tbl[i].out);
                    chk($sformatf("t%0d_busy_e%0d", r, e), {31'd0, busy}, {31'd0, tbl[i].busy});
                    chk($sformatf("t%0d_done_e%0d", r, e), {31'd0, done}, {31'd0, tbl[i].done});
                end
            end
        end

        // Back-to-back burst of three.
        reverse_skew = 1'b0;
        ecnt = -1;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] b;
            b = 8'h10 + 8'(i);
            push_vec({b, b, b, b}, (i == 2), acc);
            rec();
        end
        while (ecnt < 10) begin
            tick();
            rec();
        end
        check_hist("b2b", 16'b0000_0000_0000_1110, 7);

        // Underflow bubble between A and B.
        ecnt = -1;
        push_vec(32'hA3A2A1A0, 1'b0, acc);
        rec();
        tick(); rec();
        tick(); rec();
        push_vec(32'hB3B2B1B0, 1'b1, acc);
        rec();
        while (ecnt < 10) begin
            tick();
            rec();
        end
        check_hist("bubble", 16'b0000_0000_0001_0010, 8);

        // FIFO full while the prior burst drains.
        push_vec(32'h33323130, 1'b1, acc0);
        for (int v = 0; v < 5; v++) begin
            logic [7:0] b;
            b = 8'h40 + 8'(v * 4);
            push_vec({b + 8'd3, b + 8'd2, b + 8'd1, b}, (v == 4), accs[v]);
        end
        chk("full_acc0", 32'(accs[0] - acc0), 32'd1);
        chk("full_acc1", 32'(accs[1] - acc0), 32'd2);
        chk("full_acc2", 32'(accs[2] - acc0), 32'd3);
        chk("full_acc3", 32'(accs[3] - acc0), 32'd4);
        chk("full_acc4", 32'(accs[4] - acc0), 32'd7);
        waited = 0;
        while (!done && waited < 40) begin
            tick();
            waited++;
        end
        chk("full_done_seen", {31'd0, done}, 32'h1);
        tick();
        for (int k = 0; k < 4; k++) chk($sformatf("full_q%0d_empty", k), 32'(exp_q[k].size()), 32'd0);

        // Asynchronous reset in the middle of a stream.
        push_vec(32'hC3C2C1C0, 1'b0, acc);
        push_vec(32'hD3D2D1D0, 1'b0, acc);
        chk("ar_busy_before", {31'd0, busy}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_edge_out", edge_out, 32'h0);
        chk("ar_edge_valid", {28'd0, edge_valid}, 32'h0);
        chk("ar_busy", {31'd0, busy}, 32'h0);
        chk("ar_in_ready", {31'd0, in_ready}, 32'h1);
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("ar_post_valid_%0d", i), {28'd0, edge_valid}, 32'h0);
            chk($sformatf("ar_post_done_%0d", i), {31'd0, done}, 32'h0);
        end
        chk("ar_post_busy", {31'd0, busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multi_mode_buffer_feeder.md
Name: multi_mode_buffer_feeder

Overview:
- Transmit-side edge feeder for one side of the roundabout systolic array; drives one `multi_mode_buffer_*_in` bus.
- Accepts whole edge vectors (`PE_PER_SIDE` lanes) over a valid/ready handshake and buffers them in a small FIFO.
- Applies the diagonal systolic skew: lane k is delayed k cycles, or `PE_PER_SIDE-1-k` cycles when reversed.
- At burst end it flushes the skew pipeline with zero bubbles and pulses `done`.

Parameters:
- `DATA_WIDTH`, 8, width of one lane element.
- `PE_PER_SIDE`, 6, number of lanes (PEs on one array side).
- `FIFO_DEPTH`, 4, input vector FIFO depth; power of two, at least 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: `in_data`/`in_last` valid.
- `in_ready` out 1: FIFO not full.
- `in_data` in `DATA_WIDTH*PE_PER_SIDE`: edge vector; lane k = bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `in_last` in 1: marks the final vector of a burst.
- `reverse_skew` in 1: 0 gives lane k delay k; 1 gives lane k delay `PE_PER_SIDE-1-k`.
- `edge_out` out `DATA_WIDTH*PE_PER_SIDE`: skewed lanes to the array edge input.
- `edge_valid` out `PE_PER_SIDE`: per-lane valid.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when a burst has fully drained.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; state IDLE; all skew registers zero.
  - `edge_out`=0, `edge_valid`=0, `busy`=0, `done`=0, `in_ready`=1.
- Handshake:
  - Push occurs when `in_valid && in_ready`.
  - `in_ready` = !full; there is no pass-through when full, even if a pop happens the same cycle.
  - Pushes are accepted in every state, including DRAIN; vectors for the next burst wait in the FIFO.
- FSM (IDLE, STREAM, DRAIN):
  - IDLE, FIFO non-empty:
    - Pop on the next edge; latch `reverse_skew` into `skew_mode_q`; go to STREAM.
    - `skew_mode_q` is held until the burst returns to IDLE.
  - STREAM, FIFO non-empty: pop every edge.
  - STREAM, FIFO empty: inject a bubble (data 0, valid 0) into stage 0 and stay in STREAM. The array has no stall, so bubbles are the only gap.
  - STREAM, popped vector has `in_last`=1: go to DRAIN and load `drain_cnt` = `PE_PER_SIDE-1`.
  - DRAIN:
    - Inject bubbles and decrement `drain_cnt`; no pops.
    - When `drain_cnt` is 0, go to IDLE and assert `done` for exactly one cycle.
    - `done` rises on the same edge where `busy` falls.
- Skew pipeline:
  - Per-lane delay chain of registers, depth `PE_PER_SIDE`.
  - A vector popped at edge t appears on lane k after edge t+d_k, with d_k = k or `PE_PER_SIDE-1-k`.
  - The lane with d=0 is registered, so it shows the vector right after the pop edge.
- Latency:
  - Push into an empty FIFO in IDLE at edge t0: lane with d=0 is valid after t0+1; lane with delay d is valid after t0+1+d.
  - Last vector popped at t_L: its final lane is visible after t_L+`PE_PER_SIDE-1`; `done` is high during the cycle after t_L+`PE_PER_SIDE`.
- Invalid lanes always drive data 0.
- `PE_PER_SIDE`=1 (degenerate case): DRAIN lasts zero cycles, and `done` follows the last pop edge by one edge.
- Reset mid-burst: all state, FIFO contents and the pipeline are discarded immediately; there is no `done` pulse.
- The FIFO count has `$clog2(FIFO_DEPTH)+1` bits; read/write pointers wrap modulo `FIFO_DEPTH`.

Test Plan (`PE_PER_SIDE`=4, `DATA_WIDTH`=8, `FIFO_DEPTH`=4):
1. Single vector, no reverse: push lanes {0x04,0x03,0x02,0x01} (lane0=0x01) with last at edge 0 -> `edge_valid` goes 0001, 0010, 0100, 1000 after edges 1..4; lane k carries k+1; `done` high after edge 5 only; `busy` high after edges 1..4.
2. Reverse skew: same vector with `reverse_skew`=1 -> lane3 (0x04) appears first after edge 1 and lane0 (0x01) last after edge 4; toggling `reverse_skew` mid-burst has no effect.
3. Back-to-back burst of 3 vectors (0x10+i per lane, last on the third) -> a diagonal wavefront with no bubbles; each lane outputs 3 consecutive valid cycles; `done` 4 cycles after the third pop.
4. FIFO full: push 5 vectors while state is held in DRAIN of a prior burst -> `in_ready` drops after the 4th push, and the 5th is accepted only after the first pop; no vector is lost or duplicated (scoreboard).
5. Underflow bubble: push vector A, idle 2 cycles, push B with last -> lane0 shows A, 0/invalid, 0/invalid, B; other lanes show the same pattern shifted by k.
6. Async reset mid-STREAM: assert `rst_n`=0 between edges -> outputs go to 0 immediately; FIFO empty, `in_ready`=1, no `done` pulse after release.
